// File: rtl/esm_report_arbiter.sv
// Packet-granular round-robin arbiter merging ESM report streams onto one AXI-Stream output.
// A granted source keeps the output until its last beat; a 2-entry skid stage decouples ready.
module esm_report_arbiter #(
    parameter int NUM_INPUTS     = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int COUNT_WIDTH    = 16,
    localparam int IDX_W         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                Axis_clk,
    input  logic                                Axis_resetn,
    input  logic [NUM_INPUTS-1:0]               S_axis_valid,
    input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0] S_axis_data,
    input  logic [NUM_INPUTS-1:0]               S_axis_last,
    output logic [NUM_INPUTS-1:0]               S_axis_ready,
    output logic                                M_axis_valid,
    output logic [AXI_DATA_WIDTH-1:0]           M_axis_data,
    output logic                                M_axis_last,
    input  logic                                M_axis_ready,
    output logic                                Grant_active,
    output logic [IDX_W-1:0]                    Grant_index,
    output logic [NUM_INPUTS*COUNT_WIDTH-1:0]   Packet_count
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          rr_ptr;
    logic [IDX_W-1:0]          grant_idx;
    logic [IDX_W-1:0]          pick_idx;
    logic [IDX_W-1:0]          next_ptr;
    logic [COUNT_WIDTH-1:0]    pkt_cnt [NUM_INPUTS];

    logic                      out_valid;
    logic [AXI_DATA_WIDTH-1:0] out_data;
    logic                      out_last;
    logic                      skid_full;
    logic [AXI_DATA_WIDTH-1:0] skid_data;
    logic                      skid_last;

    logic                      accept;
    logic                      last_accept;
    logic                      drain;
    logic [AXI_DATA_WIDTH-1:0] in_data;
    logic                      in_last;

    // Round-robin pick: walk offsets from the far end so the closest requester to rr_ptr wins.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        pick_idx = rr_ptr;
        idx      = 0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (S_axis_valid[idx]) pick_idx = IDX_W'(idx);
        end
    end

    // Ready depends only on registered state, never on M_axis_ready.
    always_comb begin
        S_axis_ready = '0;
        if (state == ST_GRANTED && !skid_full) S_axis_ready[grant_idx] = 1'b1;
    end

    assign in_data     = S_axis_data[int'(grant_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign in_last     = S_axis_last[grant_idx];
    assign accept      = S_axis_valid[grant_idx] && S_axis_ready[grant_idx];
    assign last_accept = accept && in_last;
    assign drain       = out_valid && M_axis_ready;
    assign next_ptr    = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + IDX_W'(1);

    // NOTE: sequential state is written with non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Axis_clk or negedge Axis_resetn) begin
        if (!Axis_resetn) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) pkt_cnt[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|S_axis_valid) begin
                        state     <= ST_GRANTED;
                        grant_idx <= pick_idx;
                    end
                end
                ST_GRANTED: begin
                    if (last_accept) begin
                        state              <= ST_IDLE;
                        rr_ptr             <= next_ptr;
                        pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + COUNT_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register fills first; the skid register only catches the one beat that
    // arrives while the output is stalled.
    always_ff @(posedge Axis_clk or negedge Axis_resetn) begin
        if (!Axis_resetn) begin
            // NOTE: the data registers are cleared too because the zero output value is
            // externally visible after reset; the per-source counters are a small flop array.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else if (drain || !out_valid) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_last  <= skid_last;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_last  <= in_last;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_data <= in_data;
            skid_last <= in_last;
        end
    end

    assign M_axis_valid = out_valid;
    assign M_axis_data  = out_data;
    assign M_axis_last  = out_last;
    assign Grant_active = (state == ST_GRANTED);
    assign Grant_index  = grant_idx;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_count
        assign Packet_count[g*COUNT_WIDTH +: COUNT_WIDTH] = pkt_cnt[g];
    end

endmodule

// File: tb/tb_esm_report_arbiter.sv
// Self-checking bench for esm_report_arbiter: queued sources, input-side scoreboard,
// a table of arbitration vectors and hand-written sequences for the multi-cycle cases.
module tb_esm_report_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            Axis_clk = 1'b0;
    logic            Axis_resetn;
    logic [N-1:0]    S_axis_valid;
    logic [N*W-1:0]  S_axis_data;
    logic [N-1:0]    S_axis_last;
    logic [N-1:0]    S_axis_ready;
    logic            M_axis_valid;
    logic [W-1:0]    M_axis_data;
    logic            M_axis_last;
    logic            M_axis_ready;
    logic            Grant_active;
    logic [IW-1:0]   Grant_index;
    logic [N*CW-1:0] Packet_count;

    esm_report_arbiter #(.NUM_INPUTS(N), .AXI_DATA_WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .Axis_clk    (Axis_clk),
        .Axis_resetn (Axis_resetn),
        .S_axis_valid(S_axis_valid),
        .S_axis_data (S_axis_data),
        .S_axis_last (S_axis_last),
        .S_axis_ready(S_axis_ready),
        .M_axis_valid(M_axis_valid),
        .M_axis_data (M_axis_data),
        .M_axis_last (M_axis_last),
        .M_axis_ready(M_axis_ready),
        .Grant_active(Grant_active),
        .Grant_index (Grant_index),
        .Packet_count(Packet_count)
    );

    always #5 Axis_clk = ~Axis_clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [IW-1:0] exp_g;
    } vec_t;

    beat_t        src_q [N][$];
    beat_t        sb_q [$];
    logic [W-1:0] out_log [$];
    logic [3:0]   out_pkt_src [$];
    logic [N-1:0] hold;
    int           checks = 0;
    int           errors = 0;
    bit           acc_pending;
    int           acc_src;
    bit           rand_ready;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;
    bit           gap_check;
    bit           gap_arm;
    int           gap_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] tag(input int s, input int p, input int b);
        return {4'(s), 12'(p), 16'(b)};
    endfunction

    task automatic push_pkt(input int s, input int p, input int len);
        for (int b = 0; b < len; b++) begin
            beat_t e;
            e.data = tag(s, p, b);
            e.last = (b == len - 1);
            src_q[s].push_back(e);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                S_axis_valid[i]       = !hold[i];
                S_axis_data[i*W +: W] = src_q[i][0].data;
                S_axis_last[i]        = src_q[i][0].last;
            end else begin
                S_axis_valid[i]       = 1'b0;
                S_axis_data[i*W +: W] = '0;
                S_axis_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic tick();
        beat_t tmp;
        @(posedge Axis_clk);
        #1;
        if (acc_pending) begin
            tmp = src_q[acc_src].pop_front();
            acc_pending = 1'b0;
        end
        if (rand_ready) M_axis_ready = ($urandom_range(99) < 80);
        drive();
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
        out_log.delete();
        out_pkt_src.delete();
        hold         = '0;
        acc_pending  = 1'b0;
        rand_ready   = 1'b0;
        prev_stall   = 1'b0;
        gap_check    = 1'b0;
        gap_arm      = 1'b0;
        gap_cnt      = 0;
        M_axis_ready = 1'b1;
        drive();
    endtask

    task automatic do_reset(input int cycles);
        Axis_resetn = 1'b0;
        clear_bench();
        repeat (cycles) @(posedge Axis_clk);
        #1;
        Axis_resetn = 1'b1;
    endtask

    task automatic run_until_empty(input int max_cycles);
        bit done = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                src_q[3].size() == 0 && sb_q.size() == 0 && !M_axis_valid && !acc_pending) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    // Monitor: handshakes are evaluated mid-cycle, where inputs and outputs are both settled.
    always @(negedge Axis_clk) begin
        if (Axis_resetn) begin
            bit got;
            got = 1'b0;
            check("ready_onehot0", 64'($countones(S_axis_ready) <= 1), 1);
            for (int i = 0; i < N; i++) begin
                if (S_axis_valid[i] && S_axis_ready[i]) begin
                    got         = 1'b1;
                    acc_pending = 1'b1;
                    acc_src     = i;
                    sb_q.push_back(src_q[i][0]);
                end
            end
            if (got) begin
                if (gap_check && gap_arm) check("idle_gap", gap_cnt, 1);
                gap_arm = sb_q[sb_q.size()-1].last;
                gap_cnt = 0;
            end else if (gap_arm) begin
                gap_cnt++;
            end
            if (prev_stall) begin
                check("stall_valid", M_axis_valid, 1);
                check("stall_data", M_axis_data, prev_data);
                check("stall_last", M_axis_last, prev_last);
            end
            if (M_axis_valid && M_axis_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    check("out_data", M_axis_data, e.data);
                    check("out_last", M_axis_last, e.last);
                end
                out_log.push_back(M_axis_data);
                if (M_axis_last) out_pkt_src.push_back(M_axis_data[31:28]);
            end
            prev_stall = M_axis_valid && !M_axis_ready;
            prev_data  = M_axis_data;
            prev_last  = M_axis_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   tbl_cnt [N];
        int   gen_cnt [N];
        bit   held;

        tbl[0] = '{4'b1111, 2'd0};
        tbl[1] = '{4'b1111, 2'd1};
        tbl[2] = '{4'b0001, 2'd0};
        tbl[3] = '{4'b1001, 2'd3};
        tbl[4] = '{4'b1001, 2'd0};
        tbl[5] = '{4'b0110, 2'd1};
        tbl[6] = '{4'b0110, 2'd2};
        tbl[7] = '{4'b0100, 2'd2};
        tbl[8] = '{4'b1000, 2'd3};
        tbl[9] = '{4'b0011, 2'd0};

        // Reset defaults with every source requesting throughout reset.
        Axis_resetn = 1'b0;
        clear_bench();
        for (int s = 0; s < N; s++) push_pkt(s, 0, 1);
        drive();
        for (int c = 0; c < 10; c++) begin
            @(negedge Axis_clk);
            check("rst_ready", S_axis_ready, 0);
            check("rst_mvalid", M_axis_valid, 0);
        end
        check("rst_mdata", M_axis_data, 0);
        check("rst_count", Packet_count, 0);
        check("rst_grant_active", Grant_active, 0);
        check("rst_grant_index", Grant_index, 0);
        @(posedge Axis_clk);
        #1;
        Axis_resetn = 1'b1;
        @(negedge Axis_clk);
        check("release_idle_ready", S_axis_ready, 0);
        tick();
        @(negedge Axis_clk);
        check("first_grant_active", Grant_active, 1);
        check("first_grant_index", Grant_index, 0);
        check("first_grant_ready", S_axis_ready, 4'b0001);
        run_until_empty(100);

        // Arbitration table: only the granted source is allowed to complete each vector.
        do_reset(2);
        for (int i = 0; i < N; i++) tbl_cnt[i] = 0;
        for (int v = 0; v < 10; v++) begin
            for (int s = 0; s < N; s++) if (tbl[v].mask[s]) push_pkt(s, v, 1);
            drive();
            for (int n = 0; n < 20; n++) begin
                @(negedge Axis_clk);
                if (Grant_active) break;
                tick();
            end
            check("tbl_grant_active", Grant_active, 1);
            check("tbl_grant_index", Grant_index, tbl[v].exp_g);
            for (int s = 0; s < N; s++) if (s != int'(Grant_index)) src_q[s].delete();
            tbl_cnt[tbl[v].exp_g]++;
            run_until_empty(50);
        end
        for (int i = 0; i < N; i++) check("tbl_count", Packet_count[i*CW +: CW], tbl_cnt[i]);

        // Round-robin fairness with all sources continuously offering 3-beat packets.
        do_reset(2);
        for (int p = 0; p < 2; p++) for (int s = 0; s < N; s++) push_pkt(s, p, 3);
        drive();
        gap_check = 1'b1;
        run_until_empty(200);
        gap_check = 1'b0;
        check("rr_pkt_total", out_pkt_src.size(), 8);
        for (int k = 0; k < 8 && k < out_pkt_src.size(); k++) check("rr_order", out_pkt_src[k], k % 4);
        for (int i = 0; i < N; i++) check("rr_count", Packet_count[i*CW +: CW], 2);

        // No interleaving while the granted source drops valid mid-packet.
        do_reset(2);
        push_pkt(1, 0, 5);
        push_pkt(2, 1, 3);
        drive();
        held = 1'b0;
        for (int c = 0; c < 40 && !held; c++) begin
            tick();
            if (src_q[1].size() == 3) begin
                hold[1] = 1'b1;
                drive();
                for (int h = 0; h < 4; h++) begin
                    @(negedge Axis_clk);
                    check("gap_grant_active", Grant_active, 1);
                    check("gap_grant_index", Grant_index, 1);
                    check("gap_ready2", S_axis_ready[2], 0);
                    tick();
                end
                hold[1] = 1'b0;
                drive();
                held = 1'b1;
            end
        end
        if (!held) check("gap_reached", 0, 1);
        run_until_empty(100);
        check("gap_out_total", out_log.size(), 8);
        for (int k = 0; k < 8 && k < out_log.size(); k++)
            check("gap_out_order", out_log[k], (k < 5) ? tag(1, 0, k) : tag(2, 1, k - 5));

        // Skid absorption: exactly one extra beat after M_axis_ready drops.
        do_reset(2);
        push_pkt(0, 255, 6);
        drive();
        for (int c = 0; c < 20 && src_q[0].size() != 4; c++) tick();
        check("skid_reached", src_q[0].size(), 4);
        M_axis_ready = 1'b0;
        @(negedge Axis_clk);
        check("skid_absorb_ready", S_axis_ready, 4'b0001);
        tick();
        @(negedge Axis_clk);
        check("skid_ready_low", S_axis_ready, 0);
        check("skid_out_hold", M_axis_data, tag(0, 255, 1));
        tick();
        @(negedge Axis_clk);
        check("skid_ready_still_low", S_axis_ready, 0);
        M_axis_ready = 1'b1;
        run_until_empty(100);
        check("skid_out_total", out_log.size(), 6);

        // Random backpressure with 100 sequence-numbered packets of length 1..16.
        do_reset(2);
        for (int i = 0; i < N; i++) gen_cnt[i] = 0;
        for (int p = 0; p < 100; p++) begin
            int s;
            s = $urandom_range(N - 1);
            push_pkt(s, p, $urandom_range(16, 1));
            gen_cnt[s]++;
        end
        rand_ready = 1'b1;
        drive();
        run_until_empty(20000);
        rand_ready   = 1'b0;
        M_axis_ready = 1'b1;
        check("bp_sb_empty", sb_q.size(), 0);
        check("bp_pkt_total", out_pkt_src.size(), 100);
        for (int i = 0; i < N; i++) check("bp_count", Packet_count[i*CW +: CW], gen_cnt[i] % 16);

        // Single-beat packets and counter wrap on source 3.
        do_reset(2);
        for (int p = 0; p < 17; p++) push_pkt(3, p, 1);
        drive();
        run_until_empty(200);
        check("wrap_pkt_total", out_pkt_src.size(), 17);
        check("wrap_count3", Packet_count[3*CW +: CW], 1);
        check("wrap_count_others", Packet_count[3*CW-1:0], 0);

        // Reset in the middle of a packet from source 2.
        do_reset(2);
        push_pkt(2, 12, 8);
        drive();
        for (int c = 0; c < 20 && src_q[2].size() != 6; c++) tick();
        check("mid_reached", src_q[2].size(), 6);
        check("mid_valid_before", M_axis_valid, 1);
        Axis_resetn = 1'b0;
        #1;
        check("mid_rst_mvalid", M_axis_valid, 0);
        check("mid_rst_ready", S_axis_ready, 0);
        check("mid_rst_grant", Grant_active, 0);
        do_reset(3);
        push_pkt(0, 13, 4);
        drive();
        for (int c = 0; c < 20 && src_q[0].size() != 1; c++) tick();
        @(negedge Axis_clk);
        check("mid_count_before", Packet_count, 0);
        run_until_empty(100);
        check("mid_out_total", out_log.size(), 4);
        for (int k = 0; k < 4 && k < out_log.size(); k++) check("mid_out_data", out_log[k], tag(0, 13, k));
        check("mid_count_after", Packet_count[CW-1:0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/esm_report_arbiter.md
# esm_report_arbiter

Packet-granular round-robin arbiter that merges report streams from several ESM report sources into the single AXI-Stream report output (M_axis) of the receiver. Once a source is granted, it holds the output until it delivers its `last` beat, so a report packet is never interleaved with another. The block sits in the AXI clock domain, between the per-module report FIFOs and the receiver's M_axis port. It adds a registered skid stage so the downstream path has no combinational ready/valid dependency.

## Interface
Parameters:
- NUM_INPUTS, 4, number of report sources (1..8)
- AXI_DATA_WIDTH, 32, beat width in bits
- COUNT_WIDTH, 16, width of each per-input packet counter

Ports:
- Axis_clk  in  1  AXI clock; all logic is rising-edge.
- Axis_resetn  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion must be synchronous to Axis_clk, which is guaranteed externally.
- S_axis_valid  in  NUM_INPUTS  per-source valid.
- S_axis_data  in  NUM_INPUTS*AXI_DATA_WIDTH  per-source data; source i occupies bits [i*W +: W].
- S_axis_last  in  NUM_INPUTS  per-source end-of-packet.
- S_axis_ready  out  NUM_INPUTS  per-source ready; at most one bit is set at a time.
- M_axis_valid  out  1  merged output valid (registered).
- M_axis_data  out  AXI_DATA_WIDTH  merged output data (registered).
- M_axis_last  out  1  merged output last (registered).
- M_axis_ready  in  1  downstream ready.
- Grant_active  out  1  high while a source holds the grant.
- Grant_index  out  clog2(NUM_INPUTS) (minimum 1)  currently or most recently granted source.
- Packet_count  out  NUM_INPUTS*COUNT_WIDTH  per-source count of completed packets; wraps at 2^COUNT_WIDTH.

## Operation
- State machine, two states:
  - IDLE → GRANTED when any S_axis_valid is high. The grant goes to the first source with valid set, scanning from rr_ptr upward and wrapping modulo NUM_INPUTS.
  - GRANTED → IDLE on the cycle the granted source's beat with last=1 is accepted (valid && ready). On that transition, rr_ptr <= (g+1) mod NUM_INPUTS and Packet_count[g] increments.
- Ready and valid rules:
  - In IDLE, all S_axis_ready are 0.
  - In GRANTED, S_axis_ready[g] = !skid_full. All other readies are 0.
  - S_axis_valid only requests the grant. Once granted, the source may drop valid mid-packet and the grant is held indefinitely; there is no timeout.
- Output stage is a 2-entry skid buffer: an output register plus a skid register.
  - An accepted beat loads the output register if it is empty or is draining this cycle; otherwise it loads the skid register.
  - skid_full is registered state, so S_axis_ready never depends combinationally on M_axis_ready.
- Data and last are forwarded unmodified. Beat order within a packet and packet order per source are preserved.
- NUM_INPUTS=1 degenerates to a pass-through with the same one-cycle arbitration bubble per packet.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0
  - S_axis_ready all 0
  - M_axis_valid 0, M_axis_data 0, M_axis_last 0
  - skid empty
  - Grant_active 0, Grant_index 0
  - Packet_count all 0
- Arbitration latency: a request seen in IDLE in cycle n produces Grant_active=1 and S_axis_ready[g]=1 in cycle n+1.
- Data latency: a beat accepted in cycle n appears on M_axis in cycle n+1.
- Throughput: with M_axis_ready held at 1, throughput is 1 beat per cycle within a packet, plus exactly one idle input cycle between packets (the GRANTED→IDLE→GRANTED bubble).
- Backpressure: if M_axis_ready drops, at most one further beat is absorbed into the skid register. S_axis_ready[g] falls in the following cycle.
- M_axis_valid stays high until handshake. M_axis_data and M_axis_last are stable while valid && !ready.
- Simultaneous requests: resolved purely by rr_ptr. A source that just finished has the lowest priority next.
- Single-beat packet (valid && last in the same accepted beat): GRANTED lasts one cycle and the counter still increments.
- Packet_count update: registered, visible the cycle after the last beat is accepted. Wraps from 2^COUNT_WIDTH−1 to 0.
- Reset mid-packet: all state is cleared immediately and the partial packet is abandoned, with no synthetic last. After reset, arbitration restarts at source 0.

## Test plan
- **Reset defaults.** Hold Axis_resetn=0 for 10 cycles with S_axis_valid=4'b1111 → all S_axis_ready=0, M_axis_valid=0, Packet_count=0. The first grant after release is source 0.
- **Round-robin fairness.** All 4 sources continuously offer 3-beat packets with data={src,beat}, M_axis_ready=1 → output packet sources are 0,1,2,3,0,… After 8 packets, each Packet_count=2, with exactly one idle input cycle between packets.
- **No interleaving under gaps.** Source 1 sends a 5-beat packet and drops valid for 4 cycles after beat 2, while source 2 is requesting → the output shows beats 1-0..1-4 contiguous before any 2-x beat, and Grant_index=1 is held throughout.
- **Backpressure.** M_axis_ready is random with 80% high; sources send 100 packets of random length 1..16 with a sequence-numbered payload → a scoreboard matches every beat and last, with no loss or duplication. M_axis_data is stable whenever valid && !ready.
- **Single-beat packets and counter wrap.** With COUNT_WIDTH=4, source 3 sends 17 one-beat packets → Packet_count[3]=1 after wrap, and each packet appears on M_axis with last=1.
- **Reset mid-packet.** Assert reset after beat 2 of an 8-beat packet from source 2 → M_axis_valid goes to 0 within the reset assertion. After release, the next full packet from source 0 is output intact, with counters at 0 before it completes.
